// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants and types for the instruction encoder / program loader.
package instr_encoder_loader_pkg;

  // Instruction format selector values
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_IMM  = 2'b01;
  localparam logic [1:0] ERR_FMT  = 2'b10;
  localparam logic [1:0] ERR_OPC  = 2'b11;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_WR   = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_encoder_loader_instr_field_packer.sv
// Combinational RV32I field packer: builds the instruction word for the given
// format and classifies the bundle as legal or as one of three error kinds.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [1:0]  err
);

  logic fmt_ok;
  logic imm_ok;

  // I/S/B immediates are 12-bit signed values: bits 31..11 must all match.
  logic fits12;
  // J immediates are 20-bit signed halfword offsets: bits 31..19 must all match.
  logic fits20;

  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits20 = (&imm[31:19]) | ~(|imm[31:19]);

  // Field placement per format, then error classification (fmt > opcode > imm)
  always_comb begin
    word   = '0;
    err    = ERR_NONE;
    fmt_ok = 1'b1;
    imm_ok = 1'b1;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word   = {imm[11:0], rs1, funct3, rd, opcode};
        imm_ok = fits12;
      end
      FMT_S: begin
        word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        imm_ok = fits12;
      end
      FMT_B: begin
        // imm is already the halfword offset, so imm[k] lands where the
        // decoder expects byte-offset bit k+1.
        word   = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
        imm_ok = fits12;
      end
      FMT_U: begin
        word   = {imm[31:12], rd, opcode};
        imm_ok = (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        word   = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
        imm_ok = fits20;
      end
      default: fmt_ok = 1'b0;
    endcase

    if (!fmt_ok) begin
      err = ERR_FMT;
    end else if (opcode[1:0] != 2'b11) begin
      err = ERR_OPC;
    end else if (!imm_ok) begin
      err = ERR_IMM;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts instruction field bundles, encodes them into RV32I
// words and writes them to instruction memory at an auto-incrementing address.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int N         = 32,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [N-1:0]      in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              wrapped,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic [1:0]        err_code_q, err_code_d;

  // Registered field bundle (datapath only, no reset needed)
  logic [2:0]   fmt_q, fmt_d;
  logic [6:0]   opcode_q, opcode_d;
  logic [4:0]   rd_q, rd_d;
  logic [4:0]   rs1_q, rs1_d;
  logic [4:0]   rs2_q, rs2_d;
  logic [2:0]   funct3_q, funct3_d;
  logic [6:0]   funct7_q, funct7_d;
  logic [N-1:0] imm_q, imm_d;

  logic [31:0] pk_word;
  logic [1:0]  pk_err;

  instr_field_packer u_packer (
    .fmt    (fmt_q),
    .opcode (opcode_q),
    .rd     (rd_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .funct3 (funct3_q),
    .funct7 (funct7_q),
    .imm    (imm_q),
    .word   (pk_word),
    .err    (pk_err)
  );

  // Next-state, address counter, wrap flag, write data and error code
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wrapped_d  = wrapped_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;
    fmt_d      = fmt_q;
    opcode_d   = opcode_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    funct3_d   = funct3_q;
    funct7_d   = funct7_q;
    imm_d      = imm_q;
    case (state_q)
      ST_IDLE: begin
        // start wins over a simultaneous handshake; the bundle stays pending
        if (start) begin
          addr_d    = BASE;
          wrapped_d = 1'b0;
        end else if (in_valid) begin
          fmt_d    = in_fmt;
          opcode_d = in_opcode;
          rd_d     = in_rd;
          rs1_d    = in_rs1;
          rs2_d    = in_rs2;
          funct3_d = in_funct3;
          funct7_d = in_funct7;
          imm_d    = in_imm;
          state_d  = ST_ENC;
        end
      end
      ST_ENC: begin
        if (pk_err == ERR_NONE) begin
          wdata_d = pk_word;
          state_d = ST_WR;
        end else begin
          err_code_d = pk_err;
          state_d    = ST_ERR;
        end
      end
      ST_WR: begin
        if (mem_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_IDLE;
          if (addr_q == ADDR_MAX) begin
            wrapped_d = 1'b1;
          end
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= BASE;
      wrapped_q  <= 1'b0;
      wdata_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wrapped_q  <= wrapped_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

  // Field bundle capture
  always_ff @(posedge clk) begin
    fmt_q    <= fmt_d;
    opcode_q <= opcode_d;
    rd_q     <= rd_d;
    rs1_q    <= rs1_d;
    rs2_q    <= rs2_d;
    funct3_q <= funct3_d;
    funct7_q <= funct7_d;
    imm_q    <= imm_d;
  end

  // Outputs decoded straight from state so reset drops mem_we at once
  assign in_ready  = (state_q == ST_IDLE);
  assign mem_we    = (state_q == ST_WR);
  assign err_valid = (state_q == ST_ERR);
  assign busy      = (state_q != ST_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err_code  = err_code_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (ADDR_W=2 so wrap is reachable).
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        mem_we;
  logic        mem_ready;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        wrapped;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder_loader #(.N(32), .ADDR_W(2), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .err_valid (err_valid),
    .err_code  (err_code),
    .wrapped   (wrapped),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one bundle for a single handshake cycle; returns in the ENC cycle
  task automatic issue(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm);
    int waits = 0;
    while (!in_ready && waits < 20) begin
      step();
      waits++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = 7'd0; in_imm = imm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Checks a legal write with mem_ready high, starting in the ENC cycle
  task automatic write_chk(input string tag, input logic [1:0] addr, input logic [31:0] data,
                           input logic wrap_after);
    chk({tag, "_enc_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_enc_busy"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, "_data"}, mem_wdata, data);
    step();
    chk({tag, "_we_done"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr_next"}, 32'(mem_addr), 32'(addr + 2'd1));
    chk({tag, "_wrapped"}, 32'(wrapped), 32'(wrap_after));
  endtask

  // Checks an error bundle, starting in the ENC cycle
  task automatic err_chk(input string tag, input logic [1:0] code, input logic [1:0] addr);
    step();
    chk({tag, "_ev"}, 32'(err_valid), 32'd1);
    chk({tag, "_code"}, 32'(err_code), 32'(code));
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    step();
    chk({tag, "_ev_clr"}, 32'(err_valid), 32'd0);
    chk({tag, "_code_hold"}, 32'(err_code), 32'(code));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    step(); step();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ev", 32'(err_valid), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // I-type addi x1, x0, -1
    issue(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
    chk("i_enc_ready", 32'(in_ready), 32'd0);
    write_chk("i", 2'd0, 32'hFFF0_0093, 1'b0);

    // U-type lui x5, 0x12345 with start pulsed during WR (must be ignored)
    issue(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    step();
    start = 1'b1;
    chk("u_we", 32'(mem_we), 32'd1);
    chk("u_addr", 32'(mem_addr), 32'd1);
    chk("u_data", mem_wdata, 32'h1234_52B7);
    step();
    start = 1'b0;
    chk("u_addr_next", 32'(mem_addr), 32'd2);
    chk("u_busy", 32'(busy), 32'd0);

    // S-type sw x2, 8(x3)
    issue(3'd2, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'd2, 32'd8);
    write_chk("s", 2'd2, 32'h0021_A423, 1'b0);

    // B-type beq x1, x2, +8 with three cycles of backpressure
    mem_ready = 1'b0;
    issue(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("b_hold_we", 32'(mem_we), 32'd1);
      chk("b_hold_addr", 32'(mem_addr), 32'd3);
      chk("b_hold_data", mem_wdata, 32'h0020_8463);
      chk("b_hold_ready", 32'(in_ready), 32'd0);
      step();
    end
    mem_ready = 1'b1;
    chk("b_we_last", 32'(mem_we), 32'd1);
    step();
    chk("b_we_done", 32'(mem_we), 32'd0);
    chk("b_addr_wrap", 32'(mem_addr), 32'd0);
    chk("b_wrapped", 32'(wrapped), 32'd1);

    // Errors: no write, address unchanged
    issue(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
    err_chk("e_imm", 2'b01, 2'd0);
    issue(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    err_chk("e_fmt", 2'b10, 2'd0);
    issue(3'd1, 7'b0010000, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
    err_chk("e_opc", 2'b11, 2'd0);
    issue(3'd7, 7'b0010000, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    err_chk("e_prio", 2'b10, 2'd0);
    chk("e_wdata_kept", mem_wdata, 32'h0020_8463);

    // Fifth legal write lands at address 0, wrapped stays set
    issue(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0);
    write_chk("r5", 2'd0, 32'h0020_81B3, 1'b1);

    // start with in_valid in IDLE: reload wins, bundle dropped
    in_fmt = 3'd1; in_opcode = 7'b0010011; in_imm = 32'd1;
    start = 1'b1; in_valid = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("sv_addr", 32'(mem_addr), 32'd0);
    chk("sv_wrapped", 32'(wrapped), 32'd0);
    chk("sv_busy", 32'(busy), 32'd0);
    step();
    chk("sv_busy2", 32'(busy), 32'd0);
    chk("sv_we", 32'(mem_we), 32'd0);

    issue(3'd1, 7'b0010011, 5'd2, 5'd1, 5'd0, 3'd0, 32'h0000_07FF);
    write_chk("i2", 2'd0, 32'h7FF0_8113, 1'b0);

    // Reset in the middle of a stalled write
    mem_ready = 1'b0;
    issue(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0002);
    step();
    chk("rw_we", 32'(mem_we), 32'd1);
    chk("rw_addr", 32'(mem_addr), 32'd1);
    chk("rw_data", mem_wdata, 32'h0040_00EF);
    #2 rst = 1'b1;
    #1;
    chk("rw_we_drop", 32'(mem_we), 32'd0);
    chk("rw_addr_rst", 32'(mem_addr), 32'd0);
    chk("rw_wdata_rst", mem_wdata, 32'd0);
    chk("rw_code_rst", 32'(err_code), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    step();

    issue(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
    write_chk("post", 2'd0, 32'hFFF0_0093, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the team's immediate generator.
- Accepts instruction fields (format, opcode, registers, funct, immediate) over a valid/ready handshake.
- Assembles the 32-bit RV32I instruction word and range-checks the immediate.
- Writes each assembled word into instruction memory through a backpressured write port at an auto-incrementing address. Used as the program loader and self-test stimulus source.

Parameters:
- N, 32, instruction/immediate width (only 32 supported).
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, address loaded on reset and on start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  reload address counter with BASE_ADDR, clear wrapped.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal.
- in_opcode  in  7  opcode[6:0].
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R only).
- in_imm  in  N  immediate; B/J are halfword offsets (byte offset >>1); U is the full upper value.
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  N  encoded instruction.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  00 none, 01 imm out of range, 10 illegal fmt, 11 opcode[1:0]!=11.
- wrapped  out  1  sticky: address counter has wrapped.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err_valid=0, err_code=0, wrapped=0, busy=0. FSM returns to IDLE.
- FSM states: IDLE, ENC, WR, ERR.
- IDLE:
  - in_ready=1. Handshake (in_valid and in_ready) registers all fields and moves to ENC.
  - start in IDLE has priority over a simultaneous handshake. The handshake is not taken that cycle.
- ENC (one cycle): encode and check the registered fields. Move to WR if legal, otherwise to ERR.
- WR:
  - mem_we=1. mem_addr and mem_wdata are held stable until mem_ready=1.
  - When mem_ready=1: address increments and FSM returns to IDLE.
  - Address increment from 2^ADDR_W-1 wraps to 0 and sets wrapped.
- ERR:
  - err_valid=1 for one cycle with err_code. No memory write, address unchanged. FSM returns to IDLE.
  - Error priority: fmt, then opcode, then imm.
- err_code holds its last value until the next error or reset.
- Latency: handshake in cycle 0, mem_we high in cycle 2. Maximum throughput is one instruction per 3 cycles with mem_ready tied high.
- start while busy is ignored.
- in_ready=0 in ENC, WR and ERR.
- Encodings (low 7 bits always opcode):
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}. Legal if imm[31:11] are all equal.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}. Same range rule as I.
  - B: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], op}. Same range rule as I.
  - U: {imm[31:12], rd, op}. Legal if imm[11:0]==0.
  - J: {imm[19], imm[9:0], imm[10], imm[18:11], rd, op}. Legal if imm[31:19] are all equal.
- Fields unused by a format are ignored.
- Round-trip rule: decoding mem_wdata with the team's immediate generator reproduces in_imm for every legal I/S/B/J/U input.
- Reset mid-WR: mem_we drops immediately and the write is abandoned.

Decomposition:
- Shared package holds:
  - the fmt constants (FMT_R … FMT_J);
  - the err_code constants;
  - the FSM state enum.
- One natural sub-module: instr_field_packer, purely combinational. Inputs: fmt plus fields. Outputs: word plus error code.
- The top level holds the FSM, field registers, address counter and wrapped flag.

Test Plan:
- I: fmt=1, op=0010011, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> mem_we in cycle 2, mem_addr=0, mem_wdata=0xFFF00093, then addr=1.
- U then S:
  - fmt=4, op=0110111, rd=5, imm=0x12345000 -> 0x123452B7.
  - fmt=2, op=0100011, f3=2, rs1=3, rs2=2, imm=8 -> 0x0021A423.
- B with backpressure: fmt=3, op=1100011, rs1=1, rs2=2, f3=0, imm=4, mem_ready low for 3 cycles.
  - mem_we, addr and data (0x00208463) must stay stable; in_ready=0 throughout.
  - Write completes on the first cycle mem_ready=1.
- Errors, each with no write and address unchanged:
  - fmt=1, imm=0x800 -> err_valid pulse, err_code=01.
  - fmt=6 -> err_code=10.
  - op=0010000 -> err_code=11.
- Wrap: ADDR_W=2, five legal writes -> addresses 0,1,2,3,0; wrapped=1 after the fourth write. Then start in IDLE -> addr=BASE_ADDR and wrapped=0.
- Start conflicts and reset:
  - start asserted in WR -> ignored.
  - start and in_valid together in IDLE -> counter reloaded, bundle not accepted.
  - rst asserted in WR -> mem_we=0 immediately and all outputs at reset values.
